cpu_mailbox: RTL and testbench
==============================

Name: cpu_mailbox

Overview:
- Memory-mapped responder on the cpu6502 external bus. It is the device-side end of the CPU's load/store traffic.
- CPU stores to DATA are queued into a TX FIFO and drained by the host/bench over a valid/ready stream.
- Host bytes arrive over a second stream into an RX FIFO, which the CPU pops by loading DATA.
- It sits beside ram on addr/odata/idata/rw and replaces ad-hoc bus snooping for test-case reporting.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2..256
AW, 3, log2(DEPTH)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
phi2  in  1  CPU phase-2 clock (clk2), sampled synchronously in clk
ce  in  1  chip enable (address decode done externally)
rw  in  1  1=CPU read, 0=CPU write
reg_addr  in  2  register select (cpu addr[1:0])
wdata  in  8  CPU write data (odata)
rdata  out  8  CPU read data (to idata mux)
irq_n  out  1  active-low interrupt to CPU
tx_valid  out  1  TX stream byte available
tx_ready  in  1  host accepts TX byte
tx_data  out  8  TX stream byte (FIFO head)
rx_valid  in  1  host offers RX byte
rx_ready  out  1  RX FIFO can accept
rx_data  in  8  RX stream byte
done  out  1  sticky end-of-test flag
done_code  out  8  code written with done

Behaviour:
- Reset (async assert, sync release): both FIFOs empty; ovf, udf, ien, done cleared; done_code=0; irq_n=1; tx_valid=0; rx_ready=1; rdata=0; phi2_q=0.
- Bus strobe: stb = ce & phi2 & ~phi2_q, where phi2_q is phi2 registered in clk. Exactly one strobe per CPU cycle. All register side effects commit on stb. ce/rw/reg_addr/wdata must be stable on the strobe cycle.
- rdata: combinational when ce&rw, else 0. Its value is unaffected by the same-cycle pop.
- Register map:
  - 0 DATA. Write: push wdata to TX. If TX full, byte is dropped and ovf set. Read: returns RX head and pops. If RX empty, returns 8'h00 and sets udf.
  - 1 STATUS (read): {2'b0, udf, ovf, rx_full, rx_empty, tx_empty, tx_full}. Write: bit4=1 clears ovf, bit5=1 clears udf (W1C). Other bits ignored.
  - 2 IEN: bit0 = RX-not-empty interrupt enable, bit1 = TX-empty enable. Read returns {6'b0, ien}.
  - 3 DONE. Write: done<=1, done_code<=wdata. Further writes update done_code only. Read returns done_code.
- irq_n registered: irq_n <= ~((ien[0] & ~rx_empty) | (ien[1] & tx_empty)). One-cycle latency from FIFO state change.
- TX stream: tx_valid = ~tx_empty; tx_data = head. Pop on tx_valid & tx_ready. tx_data must hold while tx_valid & ~tx_ready.
- RX stream: rx_ready = ~rx_full; push on rx_valid & rx_ready.
- Simultaneous push+pop on one FIFO in one cycle:
  - Non-empty and non-full: count unchanged, both succeed.
  - Full: both succeed, no overflow.
  - Empty: pop is invalid. For TX this cannot happen since tx_valid=0; for RX, udf is set and the push still lands.
- Pointers: AW-bit, wrap modulo DEPTH. Count is AW+1 bits; full = count==DEPTH.
- Both FIFOs fall-through: data written in cycle N is visible at the head in cycle N+1.
- Reset mid-operation: FIFO contents are discarded. A strobe concurrent with reset is ignored.

Decomposition:
- Package cpu_mailbox_pkg: register offsets (REG_DATA=0, REG_STATUS=1, REG_IEN=2, REG_DONE=3) and STATUS/IEN bit-index constants.
- One sub-module mailbox_fifo (DEPTH/AW params; push, pop, wdata, rdata, full, empty, count), instantiated twice for TX and RX.

Test Plan:
- Reset: hold reset_n=0 -> irq_n=1, tx_valid=0, rx_ready=1, done=0, STATUS read=8'h06.
- TX ordering:
  - CPU writes 0x11,0x22,0x33 to DATA with tx_ready=0 -> tx_valid=1, tx_data=0x11.
  - Then raise tx_ready -> 0x11,0x22,0x33 on three consecutive cycles, then tx_valid=0.
- TX overflow: 9 DATA writes with tx_ready=0 (DEPTH=8) -> 9th dropped, STATUS=8'h11; write STATUS 0x10 -> STATUS=8'h01.
- RX path: host pushes 0xA5 with IEN=1 -> irq_n=0 one cycle after push. CPU reads DATA -> 0xA5, irq_n returns to 1. Second read -> 0x00 and STATUS bit5=1.
- Simultaneous full push/pop: fill RX to 8, in the same cycle host pushes 0x77 and CPU pops DATA -> count stays 8, no flags, 0x77 read last.
- DONE: write 0x00 then 0x42 to reg 3 -> done=1 after first strobe; done_code=0x42; reg-3 read=0x42.

Source files
------------

// File: rtl/cpu_mailbox_pkg.sv
// Shared register map and bit positions for the cpu6502 mailbox responder.
package cpu_mailbox_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_IEN    = 2'd2,
    REG_DONE   = 2'd3
  } reg_sel_e;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_OVF      = 4;
  localparam int unsigned ST_UDF      = 5;

  localparam int unsigned IEN_RX = 0;
  localparam int unsigned IEN_TX = 1;

endpackage

// File: rtl/cpu_mailbox_fifo.sv
// Fall-through byte FIFO; a pop on empty is ignored, a push on full lands only with a same-cycle pop.
module mailbox_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mailbox.sv
// Memory-mapped mailbox on the cpu6502 bus: CPU stores feed a TX stream, host RX stream feeds CPU loads.
module cpu_mailbox
  import cpu_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       phi2,
  input  logic       ce,
  input  logic       rw,
  input  logic [1:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq_n,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       done,
  output logic [7:0] done_code
);

  reg_sel_e    sel;
  logic        phi2_q;
  logic        stb;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic [AW:0] tx_count, rx_count;
  logic        ovf, udf;
  logic [1:0]  ien;
  logic [7:0]  status;
  logic        unused_counts;

  assign sel     = reg_sel_e'(reg_addr);
  assign stb     = ce & phi2 & ~phi2_q;
  assign tx_push = stb & ~rw & (sel == REG_DATA);
  assign rx_pop  = stb &  rw & (sel == REG_DATA);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  // A CPU pop in the same cycle frees a slot, so a full RX FIFO still accepts the host byte.
  assign rx_ready = ~rx_full | rx_pop;
  assign rx_push  = rx_valid & rx_ready;
  assign unused_counts = ^{tx_count, rx_count};

  mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .wdata(wdata),
    .rdata(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign status = {2'b00, udf, ovf, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rdata = '0;
    if (ce & rw) begin
      case (sel)
        REG_DATA:   rdata = rx_empty ? 8'h00 : rx_head;
        REG_STATUS: rdata = status;
        REG_IEN:    rdata = {6'b0, ien};
        REG_DONE:   rdata = done_code;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi2_q    <= 1'b0;
      irq_n     <= 1'b1;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      ien       <= '0;
      done      <= 1'b0;
      done_code <= '0;
    end else begin
      phi2_q <= phi2;
      irq_n  <= ~((ien[IEN_RX] & ~rx_empty) | (ien[IEN_TX] & tx_empty));
      if (rx_pop & rx_empty) udf <= 1'b1;
      if (stb & ~rw) begin
        case (sel)
          REG_DATA: if (tx_full & ~tx_pop) ovf <= 1'b1;
          REG_STATUS: begin
            if (wdata[ST_OVF]) ovf <= 1'b0;
            if (wdata[ST_UDF]) udf <= 1'b0;
          end
          REG_IEN: ien <= wdata[1:0];
          REG_DONE: begin
            done      <= 1'b1;
            done_code <= wdata;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_mailbox.sv
// Directed bench for cpu_mailbox: bus accesses, both streams, flags, irq latency and done.
module tb_cpu_mailbox;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       phi2, ce, rw;
  logic [1:0] reg_addr;
  logic [7:0] wdata, rdata;
  logic       irq_n;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       done;
  logic [7:0] done_code;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q;

  cpu_mailbox #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .phi2(phi2), .ce(ce), .rw(rw),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .irq_n(irq_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .done_code(done_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One CPU cycle: phi2 rises at a negedge (one strobe), drops at the next.
  task automatic bus(input logic r, input logic [1:0] a, input logic [7:0] d, output logic [7:0] rd);
    @(negedge clk);
    ce = 1'b1; rw = r; reg_addr = a; wdata = d; phi2 = 1'b1;
    #1 rd = rdata;
    @(negedge clk);
    ce = 1'b0; rw = 1'b1; phi2 = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus(1'b0, a, d, dummy);
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] rd);
    bus(1'b1, a, 8'h00, rd);
  endtask

  task automatic host_push(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; phi2 = 1'b0; ce = 1'b0; rw = 1'b1; reg_addr = 2'd0;
    wdata = 8'h00; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_irq_n", {7'b0, irq_n}, 8'h01);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_done", {7'b0, done}, 8'h00);
    ce = 1'b1; rw = 1'b1; reg_addr = 2'd1;
    #1 chk("rst_status", rdata, 8'h06);
    ce = 1'b0; reg_addr = 2'd0;
    @(negedge clk) reset_n = 1'b1;

    // TX ordering
    cpu_wr(2'd0, 8'h11); cpu_wr(2'd0, 8'h22); cpu_wr(2'd0, 8'h33);
    #1;
    chk("tx_valid_held", {7'b0, tx_valid}, 8'h01);
    chk("tx_head_held", tx_data, 8'h11);
    @(negedge clk) tx_ready = 1'b1;
    #1 chk("tx_b0", tx_data, 8'h11);
    @(negedge clk); #1 chk("tx_b1", tx_data, 8'h22);
    @(negedge clk); #1 chk("tx_b2", tx_data, 8'h33);
    @(negedge clk); #1 chk("tx_drained", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // TX overflow, with one byte parked in RX so rx_empty is clear
    host_push(8'h5A);
    for (int i = 1; i <= 9; i++) cpu_wr(2'd0, 8'(i));
    cpu_rd(2'd1, q); chk("ovf_status", q, 8'h11);
    chk("ovf_head", tx_data, 8'h01);
    cpu_wr(2'd1, 8'h10);
    cpu_rd(2'd1, q); chk("ovf_clear", q, 8'h01);
    @(negedge clk) tx_ready = 1'b1;
    #1 chk("ovf_drain_1", tx_data, 8'h01);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk); #1 chk("ovf_drain", tx_data, 8'(i));
    end
    @(negedge clk); #1 chk("ovf_drained", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    cpu_rd(2'd0, q); chk("rx_parked", q, 8'h5A);

    // RX path and irq latency
    cpu_wr(2'd2, 8'h01);
    cpu_rd(2'd2, q); chk("ien_rd", q, 8'h01);
    host_push(8'hA5);
    #1 chk("irq_not_yet", {7'b0, irq_n}, 8'h01);
    @(negedge clk); #1 chk("irq_asserted", {7'b0, irq_n}, 8'h00);
    cpu_rd(2'd0, q); chk("rx_a5", q, 8'hA5);
    #1 chk("irq_still_low", {7'b0, irq_n}, 8'h00);
    @(negedge clk); #1 chk("irq_released", {7'b0, irq_n}, 8'h01);
    cpu_rd(2'd0, q); chk("rx_empty_rd", q, 8'h00);
    cpu_rd(2'd1, q); chk("udf_status", q, 8'h26);
    cpu_wr(2'd1, 8'h20);
    cpu_rd(2'd1, q); chk("udf_clear", q, 8'h06);
    cpu_wr(2'd2, 8'h02);
    @(negedge clk); #1 chk("irq_tx_empty", {7'b0, irq_n}, 8'h00);
    cpu_wr(2'd2, 8'h00);

    // RX full with simultaneous host push and CPU pop
    for (int i = 1; i <= 8; i++) host_push(8'(i));
    #1 chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    cpu_rd(2'd1, q); chk("rx_full_status", q, 8'h0A);
    @(negedge clk);
    ce = 1'b1; rw = 1'b1; reg_addr = 2'd0; phi2 = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h77;
    #1 chk("sim_pop_data", rdata, 8'h01);
    chk("sim_ready", {7'b0, rx_ready}, 8'h01);
    @(negedge clk);
    ce = 1'b0; phi2 = 1'b0; rx_valid = 1'b0;
    cpu_rd(2'd1, q); chk("sim_status", q, 8'h0A);
    for (int i = 2; i <= 8; i++) begin
      cpu_rd(2'd0, q); chk("sim_drain", q, 8'(i));
    end
    cpu_rd(2'd0, q); chk("sim_last", q, 8'h77);
    cpu_rd(2'd1, q); chk("sim_end_status", q, 8'h06);

    // DONE
    cpu_wr(2'd3, 8'h00);
    #1 chk("done_set", {7'b0, done}, 8'h01);
    chk("done_code0", done_code, 8'h00);
    cpu_wr(2'd3, 8'h42);
    #1 chk("done_code42", done_code, 8'h42);
    chk("done_sticky", {7'b0, done}, 8'h01);
    cpu_rd(2'd3, q); chk("done_rd", q, 8'h42);

    // Reset mid-operation discards FIFO contents and flags
    cpu_wr(2'd0, 8'h99);
    #1 chk("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
    chk("mid_rst_done", {7'b0, done}, 8'h00);
    chk("mid_rst_code", done_code, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
